// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the oversampling UART receiver:
//   - state_t              : 3-bit receiver FSM state encoding
//   - DATA_BITS            : data bits per frame (8)
//   - CLKS_PER_BIT_DEFAULT : default clocks per serial bit (50 MHz / 115200 baud)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for an asynchronous, idle-high serial line.
// Both flops reset to 1 so a reset never looks like a start bit.
// Ports:
//   i_Clock : sampling clock (rising edge)
//   i_Reset : synchronous active-high reset
//   i_D     : asynchronous input
//   o_Q     : synchronized output
// -----------------------------------------------------------------------------
module uart_sync2 (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_D,
    output logic o_Q
);

    logic r_meta;
    logic r_sync;

    // NOTE: sequential state uses non-blocking assignments so both flops
    // sample their inputs from the same edge; blocking here would collapse
    // the two stages into one.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_D;
            r_sync <= r_meta;
        end
    end

    assign o_Q = r_sync;

endmodule

// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
// UART receiver, 8 data bits LSB first, one stop bit, sampling each bit at its
// centre using a free bit-clock counter of CLKS_PER_BIT cycles per bit.
// Optional even parity bit is enabled by defining the macro UART_RX_PARITY_EN.
// Parameters:
//   CLKS_PER_BIT    : clocks per serial bit, even, 4..65535
// Ports:
//   i_Clock         : clock, rising edge
//   i_Reset         : synchronous active-high reset
//   i_Rx_Serial     : asynchronous serial line, idle high
//   o_Rx_DV         : one-cycle pulse, o_Rx_Byte holds a valid error-free byte
//   o_Rx_Byte       : last received byte (loaded at every stop sample)
//   o_Rx_Frame_Err  : one-cycle pulse, stop bit sampled low
//   o_Rx_Parity_Err : one-cycle pulse, even-parity mismatch (0 without parity)
//   o_Rx_Busy       : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Rx_Frame_Err,
    output logic                 o_Rx_Parity_Err,
    output logic                 o_Rx_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = S_PARITY;
`else
    localparam state_t AFTER_DATA = S_STOP;
`endif

    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_W-1:0]     r_count;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_byte;
    logic                 r_dv;
    logic                 r_fe;
    logic                 w_rx_s;
    logic                 w_half;
    logic                 w_centre;
    logic                 w_stop_sample;
    logic                 w_par_err;

    uart_sync2 u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_D     (i_Rx_Serial),
        .o_Q     (w_rx_s)
    );

    assign w_half        = (r_count == HALF_M1);
    assign w_centre      = (r_count == FULL_M1);
    assign w_stop_sample = (r_state == S_STOP) && w_centre;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    // NOTE: w_next_state gets its hold value before the case so every path
    // assigns it; a missing default here would infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:   if (!w_rx_s) w_next_state = S_START;
            // Half a bit in: still low means a real start bit, high was a glitch.
            S_START:  if (w_half) w_next_state = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (w_centre && r_bit_idx == LAST_BIT) w_next_state = AFTER_DATA;
            S_PARITY: if (w_centre) w_next_state = S_STOP;
            S_STOP:   if (w_centre) w_next_state = w_rx_s ? S_IDLE : S_BREAK;
            // Wait out a held-low line; no start detection until it is high.
            S_BREAK:  if (w_rx_s) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_count   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_byte    <= '0;
            r_dv      <= 1'b0;
            r_fe      <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            r_fe <= 1'b0;

            // Counter restarts on every state change and every bit centre, so
            // it never exceeds CLKS_PER_BIT-1 inside a bit.
            if (r_state == S_IDLE || r_state == S_BREAK ||
                w_next_state != r_state || w_centre)
                r_count <= '0;
            else
                r_count <= r_count + CNT_W'(1);

            if (r_state == S_START) begin
                r_bit_idx <= '0;
            end else if (r_state == S_DATA && w_centre) begin
                r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end

            // Byte is exposed even on error so a bad frame can be inspected.
            if (w_stop_sample) begin
                r_byte <= r_shift;
                r_dv   <= w_rx_s & ~w_par_err;
                r_fe   <= ~w_rx_s;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_parity_bit;
    logic r_pe;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_parity_bit <= 1'b0;
            r_pe         <= 1'b0;
        end else begin
            r_pe <= 1'b0;
            if (r_state == S_PARITY && w_centre) r_parity_bit <= w_rx_s;
            if (w_stop_sample)                   r_pe         <= w_par_err;
        end
    end

    // Even parity: data bits plus parity bit must XOR to zero.
    assign w_par_err       = ^{r_shift, r_parity_bit};
    assign o_Rx_Parity_Err = r_pe;
`else
    assign w_par_err       = 1'b0;
    assign o_Rx_Parity_Err = 1'b0;
`endif

    assign o_Rx_DV        = r_dv;
    assign o_Rx_Byte      = r_byte;
    assign o_Rx_Frame_Err = r_fe;
    assign o_Rx_Busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os
// Directed plus randomized frames against uart_rx_os with CLKS_PER_BIT=8.
// Expected pulses and their cycles come from frame-level arithmetic: a pulse is
// due LATENCY cycles after the start-bit falling edge, its kind is decided by
// the stop level and the even-parity rule. Parity cases run when the bench is
// built with UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uart_rx_os;

    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_CYC = (10 + PAR_BITS) * CPB;
    localparam int LATENCY   = 2 + CPB / 2 + (9 + PAR_BITS) * CPB + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       dv;
    logic [7:0] rbyte;
    logic       fe;
    logic       pe;
    logic       busy;

    uart_rx_os #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock         (clk),
        .i_Reset         (rst),
        .i_Rx_Serial     (rx),
        .o_Rx_DV         (dv),
        .o_Rx_Byte       (rbyte),
        .o_Rx_Frame_Err  (fe),
        .o_Rx_Parity_Err (pe),
        .o_Rx_Busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] b;
    } ev_t;

    ev_t dv_q[$];
    int  fe_q[$];
    int  pe_q[$];

    always @(negedge clk) begin
        ev_t e;
        if (dv === 1'b1) begin
            e.cyc = cyc;
            e.b   = rbyte;
            dv_q.push_back(e);
        end
        if (fe === 1'b1) fe_q.push_back(cyc);
        if (pe === 1'b1) pe_q.push_back(cyc);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        dv_q.delete();
        fe_q.delete();
        pe_q.delete();
    endtask

    task automatic hold(input logic lvl, input int n);
        rx = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit, data bits LSB first, and the parity bit when enabled.
    task automatic send_body(input logic [7:0] d, input logic par, output int fall);
        fall = cyc;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
        if (PAR_BITS != 0) hold(par, CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, output int fall);
        send_body(d, par, fall);
        hold(1'b1, CPB);
    endtask

    // Reference model: one frame's expected pulses from data, parity and stop level.
    task automatic check_frame(input string tag, input logic [7:0] d, input logic par,
                               input int fall, input bit stop_high);
        bit exp_pe;
        bit exp_fe;
        bit exp_dv;
        int t;
        exp_pe = (PAR_BITS != 0) && ((^d ^ par) == 1'b1);
        exp_fe = !stop_high;
        exp_dv = !exp_pe && !exp_fe;
        t      = fall + LATENCY;
        check({tag, " dv_count"}, 32'(dv_q.size()), 32'(exp_dv));
        check({tag, " fe_count"}, 32'(fe_q.size()), 32'(exp_fe));
        check({tag, " pe_count"}, 32'(pe_q.size()), 32'(exp_pe));
        if (exp_dv && dv_q.size() != 0) begin
            check({tag, " dv_cycle"}, 32'(dv_q[0].cyc), 32'(t));
            check({tag, " dv_byte"}, 32'(dv_q[0].b), 32'(d));
        end
        if (exp_fe && fe_q.size() != 0) check({tag, " fe_cycle"}, 32'(fe_q[0]), 32'(t));
        if (exp_pe && pe_q.size() != 0) check({tag, " pe_cycle"}, 32'(pe_q[0]), 32'(t));
        check({tag, " byte_out"}, 32'(rbyte), 32'(d));
        clear_q();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         fall_a;
        int         fall_b;
        int         k;
        logic [7:0] d;
        logic       par;
        int         gap;

        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset dv", 32'(dv), 32'(0));
        check("reset byte", 32'(rbyte), 32'(0));
        check("reset fe", 32'(fe), 32'(0));
        check("reset pe", 32'(pe), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        rst = 1'b0;
        hold(1'b1, 4);
        clear_q();

        // Single clean frame
        send_frame(8'h54, 1'b1, fall_a);
        hold(1'b1, 2);
        check("f54 latency_const", 32'(LATENCY - PAR_BITS * CPB), 32'(79));
        check_frame("f54", 8'h54, 1'b1, fall_a, 1'b1);

        // Back-to-back frames, no idle gap
        send_frame(8'hA5, 1'b0, fall_a);
        send_frame(8'h3C, 1'b0, fall_b);
        hold(1'b1, 2);
        check("b2b dv_count", 32'(dv_q.size()), 32'(2));
        check("b2b fe_count", 32'(fe_q.size()), 32'(0));
        if (dv_q.size() == 2) begin
            check("b2b byte0", 32'(dv_q[0].b), 32'(8'hA5));
            check("b2b byte1", 32'(dv_q[1].b), 32'(8'h3C));
            check("b2b cycle0", 32'(dv_q[0].cyc), 32'(fall_a + LATENCY));
            check("b2b spacing", 32'(dv_q[1].cyc - dv_q[0].cyc), 32'(FRAME_CYC));
        end
        clear_q();

        // 3-cycle glitch on an idle line
        hold(1'b0, 3);
        rx = 1'b1;
        k  = 0;
        while (busy !== 1'b0 && k < 7) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("glitch busy_idle", 32'(busy), 32'(0));
        hold(1'b1, 2 * CPB);
        check("glitch dv_count", 32'(dv_q.size()), 32'(0));
        check("glitch fe_count", 32'(fe_q.size()), 32'(0));
        check("glitch byte_kept", 32'(rbyte), 32'(8'h3C));
        clear_q();

        // Stop bit held low for 20 bits
        send_body(8'hFF, 1'b0, fall_a);
        hold(1'b0, 2 * CPB);
        check("break busy_early", 32'(busy), 32'(1));
        hold(1'b0, 18 * CPB);
        check("break busy_late", 32'(busy), 32'(1));
        rx = 1'b1;
        k  = 0;
        while (busy !== 1'b0 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("break busy_release", 32'(busy), 32'(0));
        hold(1'b1, CPB);
        check_frame("break", 8'hFF, 1'b0, fall_a, 1'b0);

        // Reset in the middle of data bit 4 of 0x81, released during bit 7
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(i == 0, CPB);
        hold(1'b0, CPB / 2);
        rst = 1'b1;
        hold(1'b0, CPB / 2);
        check("rst_mid busy", 32'(busy), 32'(0));
        check("rst_mid byte", 32'(rbyte), 32'(0));
        hold(1'b0, 2 * CPB);
        hold(1'b1, CPB / 2);
        rst = 1'b0;
        hold(1'b1, CPB / 2);
        hold(1'b1, 3 * CPB);
        check("rst_mid dv_count", 32'(dv_q.size()), 32'(0));
        check("rst_mid fe_count", 32'(fe_q.size()), 32'(0));
        check("rst_mid byte_after", 32'(rbyte), 32'(0));
        clear_q();
        send_frame(8'h81, 1'b0, fall_a);
        hold(1'b1, 2);
        check_frame("f81", 8'h81, 1'b0, fall_a, 1'b1);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so parity bit must be 1
        send_frame(8'h07, 1'b0, fall_a);
        hold(1'b1, 2);
        check_frame("par_bad", 8'h07, 1'b0, fall_a, 1'b1);
        send_frame(8'h07, 1'b1, fall_a);
        hold(1'b1, 2);
        check_frame("par_good", 8'h07, 1'b1, fall_a, 1'b1);
`endif

        // Randomized frames with random idle gaps
        for (int n = 0; n < 8; n++) begin
            d   = 8'($urandom_range(0, 255));
            par = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 12);
            if (gap > 0) hold(1'b1, gap);
            send_frame(d, par, fall_a);
            hold(1'b1, 2);
            check_frame($sformatf("rand%0d", n), d, par, fall_a, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, i_Clock cycles per serial bit (50 MHz / 115200 baud); legal values are 4 to 65535, even only.
REQ-002 i_Clock  input  1  sole clock; all logic is on the rising edge.
REQ-003 i_Reset  input  1  synchronous, active-high reset.
REQ-004 i_Rx_Serial  input  1  asynchronous serial line, idle high.
REQ-005 o_Rx_DV  output  1  one-cycle pulse: o_Rx_Byte holds a valid, error-free byte.
REQ-006 o_Rx_Byte  output  8  last received byte.
REQ-007 o_Rx_Frame_Err  output  1  one-cycle pulse: stop bit sampled low.
REQ-008 o_Rx_Parity_Err  output  1  one-cycle pulse: parity mismatch; tied 0 without UART_RX_PARITY_EN.
REQ-009 o_Rx_Busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 i_Rx_Serial shall pass through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-011 FSM states shall be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-012 IDLE: rx_s=0 moves to START and clears the bit-clock counter.
REQ-013 START: at count CLKS_PER_BIT/2-1, rx_s=0 moves to DATA with counter cleared; rx_s=1 is a glitch and returns to IDLE with no output pulse.
REQ-014 DATA: sample rx_s at each count CLKS_PER_BIT-1 (bit centre); 8 bits LSB first into a shift register; after bit 7 go to PARITY (macro on) or STOP.
REQ-015 PARITY: sample the parity bit at bit centre; error if XOR(data bits, parity bit) != 0 (even parity).
REQ-016 STOP: sample at bit centre; o_Rx_Byte shall load the shift register in the same cycle regardless of errors.
REQ-017 STOP with rx_s=1 and no parity error: o_Rx_DV=1 next cycle for exactly one cycle, then IDLE.
REQ-018 STOP with rx_s=1 and a parity error: o_Rx_Parity_Err=1 for one cycle, o_Rx_DV stays 0, then IDLE.
REQ-019 STOP with rx_s=0: o_Rx_Frame_Err=1 for one cycle and o_Rx_DV stays 0. If a parity error also exists, both error pulses assert together. Then go to BREAK.
REQ-020 BREAK: remain until rx_s=1, then IDLE; no new start detection occurs in BREAK.
REQ-021 Latency, no parity: o_Rx_DV high in cycle 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 after the i_Rx_Serial falling edge. With parity, add CLKS_PER_BIT.
REQ-022 A start bit beginning in the cycle IDLE is re-entered shall be detected (back-to-back frames, no gap required).
REQ-023 The bit counter shall be wide enough for CLKS_PER_BIT-1 and shall never wrap within a bit.

Reset
REQ-024 i_Reset=1 shall force IDLE and clear the counter, the bit index and the shift register. Outputs take these values: o_Rx_DV=0, o_Rx_Byte=8'h00, o_Rx_Frame_Err=0, o_Rx_Parity_Err=0, o_Rx_Busy=0. Synchronizer flops reset to 1.
REQ-025 Reset asserted mid-frame shall abandon the frame with no output pulse. After release, the remaining bits of that frame shall be treated as line activity from IDLE.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: a frame is 11 bits (start, 8 data, even parity, stop) and the PARITY state is present.
REQ-027 Macro UART_RX_PARITY_EN undefined: a frame is 10 bits, PARITY is unreachable or omitted, and o_Rx_Parity_Err is constant 0.

Structure
REQ-028 Package uart_pkg shall hold the FSM state encoding (3-bit), DATA_BITS=8, and the default CLKS_PER_BIT.
REQ-029 Sub-module uart_sync2 (2-flop synchronizer, reset value 1) shall be used for i_Rx_Serial.

Verification (CLKS_PER_BIT=8, no parity unless stated)
REQ-030 Drive frame 0x54 -> o_Rx_DV pulses once at cycle 79 after the falling edge, with o_Rx_Byte=0x54 and no error pulses.
REQ-031 Drive 0xA5 then 0x3C back-to-back with no idle gap -> two o_Rx_DV pulses 80 cycles apart, bytes 0xA5 then 0x3C.
REQ-032 Drive a 3-cycle low glitch on an idle line -> no output pulse; o_Rx_Busy returns to 0 within 7 cycles.
REQ-033 Drive frame 0xFF with stop held low for 20 bits -> one o_Rx_Frame_Err pulse, o_Rx_Byte=0xFF, no o_Rx_DV; o_Rx_Busy stays 1 until the line returns high.
REQ-034 Assert i_Reset at data bit 4 of 0x81 -> no pulse, o_Rx_Byte=0x00; the next clean frame 0x81 is received correctly.
REQ-035 UART_RX_PARITY_EN defined, frame 0x07 with parity bit 0 -> o_Rx_Parity_Err pulse and no o_Rx_DV; with parity bit 1 -> o_Rx_DV with 0x07.
